// File: rtl/stack_unit.sv
// stack_unit: parametrised hardware stack with registered top/next/third outputs.
// Optional feature macro STACK_GUARD_EN: blocks overflow/underflow ops and reports them on err/err_code.
module stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         din,
    input  logic                     clr,
    output logic [WIDTH-1:0]         tos,
    output logic [WIDTH-1:0]         nos,
    output logic [WIDTH-1:0]         ros,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     err,
    output logic [1:0]               err_code,
    input  logic                     err_clr
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] OP_PUSH     = 3'd1;
    localparam logic [2:0] OP_POP      = 3'd2;
    localparam logic [2:0] OP_POP2PUSH = 3'd3;
    localparam logic [2:0] OP_DUP      = 3'd4;
    localparam logic [2:0] OP_SWAP     = 3'd5;
    localparam logic [2:0] OP_ROT      = 3'd6;
    localparam logic [2:0] OP_REPLACE  = 3'd7;

    localparam logic [AW:0]   SP_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   SP_TWO   = (AW+1)'(2);
    localparam logic [AW:0]   SP_THREE = (AW+1)'(3);
    localparam logic [AW:0]   SP_MASK  = {1'b0, {AW{1'b1}}};
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_next;
    logic [AW-1:0]     cnt;
    logic [AW:0]       sp, sp_calc, sp_next;
    logic [WIDTH-1:0]  mem [0:DEPTH-1];

    logic [AW-1:0]     idx0, idx1, idx2, idx3, idx4;
    logic [WIDTH-1:0]  t_rd, n_rd, r_rd, f_rd;
    logic [WIDTH-1:0]  t_new, n_new, r_new;
    logic              we0, we1, we2, we3;
    logic [WIDTH-1:0]  wd0, wd1, wd2, wd3;
    logic              accept, exec, violation;
    logic [1:0]        viol_code;

    // Entry addresses wrap modulo DEPTH, which also covers the unguarded wraparound case.
    assign idx0 = sp[AW-1:0];
    assign idx1 = idx0 - AW'(1);
    assign idx2 = idx0 - AW'(2);
    assign idx3 = idx0 - AW'(3);
    assign idx4 = idx0 - AW'(4);
    assign t_rd = mem[idx1];
    assign n_rd = mem[idx2];
    assign r_rd = mem[idx3];
    assign f_rd = mem[idx4];

    assign depth = sp;
    assign empty = (sp == '0);

`ifdef STACK_GUARD_EN
    logic [AW:0] need;
    logic        under, over;

    always_comb begin
        need = '0;
        case (op)
            OP_POP, OP_DUP, OP_REPLACE: need = SP_ONE;
            OP_POP2PUSH, OP_SWAP:       need = SP_TWO;
            OP_ROT:                     need = SP_THREE;
            default:                    need = '0;
        endcase
    end

    assign full      = (sp == (AW+1)'(DEPTH));
    assign under     = (sp < need);
    assign over      = ((op == OP_PUSH) || (op == OP_DUP)) && full;
    assign violation = under || over;
    assign viol_code = under ? 2'b01 : 2'b10;
    assign sp_next   = sp_calc;
`else
    assign full      = 1'b0;
    assign violation = 1'b0;
    assign viol_code = 2'b00;
    assign sp_next   = sp_calc & SP_MASK;
`endif

    // A clear request in the same cycle as an op takes priority and drops the op.
    assign accept = op_valid && op_ready && !clr;
    assign exec   = accept && !violation;

    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        case (state)
            CLEAR: begin
                if (!clr && cnt == CNT_LAST) state_next = RUN;
            end
            RUN: begin
                op_ready = 1'b1;
                if (clr) state_next = CLEAR;
            end
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        sp_calc = sp;
        t_new   = t_rd;
        n_new   = n_rd;
        r_new   = r_rd;
        we0     = 1'b0;
        we1     = 1'b0;
        we2     = 1'b0;
        we3     = 1'b0;
        wd0     = din;
        wd1     = din;
        wd2     = din;
        wd3     = n_rd;
        case (op)
            OP_PUSH: begin
                sp_calc = sp + SP_ONE;
                we0     = 1'b1;
                t_new   = din;
                n_new   = t_rd;
                r_new   = n_rd;
            end
            OP_POP: begin
                sp_calc = sp - SP_ONE;
                t_new   = n_rd;
                n_new   = r_rd;
                r_new   = f_rd;
            end
            OP_POP2PUSH: begin
                sp_calc = sp - SP_ONE;
                we2     = 1'b1;
                t_new   = din;
                n_new   = r_rd;
                r_new   = f_rd;
            end
            OP_DUP: begin
                sp_calc = sp + SP_ONE;
                we0     = 1'b1;
                wd0     = t_rd;
                n_new   = t_rd;
                r_new   = n_rd;
            end
            OP_SWAP: begin
                we1   = 1'b1;
                wd1   = n_rd;
                we2   = 1'b1;
                wd2   = t_rd;
                t_new = n_rd;
                n_new = t_rd;
            end
            OP_ROT: begin
                we1   = 1'b1;
                wd1   = r_rd;
                we2   = 1'b1;
                wd2   = t_rd;
                we3   = 1'b1;
                t_new = r_rd;
                n_new = t_rd;
                r_new = n_rd;
            end
            OP_REPLACE: begin
                we1   = 1'b1;
                t_new = din;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (exec) begin
            if (we0) mem[idx0] <= wd0;
            if (we1) mem[idx1] <= wd1;
            if (we2) mem[idx2] <= wd2;
            if (we3) mem[idx3] <= wd3;
        end
    end

    // Top-of-stack view is registered; entries beyond the current depth read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            cnt      <= '0;
            sp       <= '0;
            tos      <= '0;
            nos      <= '0;
            ros      <= '0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state <= state_next;
            if (state == CLEAR && !clr) cnt <= cnt + CNT_ONE;
            else                        cnt <= '0;

            if (clr) begin
                sp  <= '0;
                tos <= '0;
                nos <= '0;
                ros <= '0;
            end else if (exec) begin
                sp  <= sp_next;
                tos <= (sp_next >= SP_ONE)   ? t_new : '0;
                nos <= (sp_next >= SP_TWO)   ? n_new : '0;
                ros <= (sp_next >= SP_THREE) ? r_new : '0;
            end

            if (state == RUN) begin
                if (accept && violation) begin
                    err <= 1'b1;
                    if (!err || err_clr) err_code <= viol_code;
                end else if (err_clr) begin
                    err      <= 1'b0;
                    err_code <= 2'b00;
                end
            end
        end
    end
endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: expected states go through a scoreboard queue and are checked with immediate asserts.
// Guard-dependent sections follow STACK_GUARD_EN.
module tb_stack_unit;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    localparam logic [2:0] NOP      = 3'd0;
    localparam logic [2:0] PUSH     = 3'd1;
    localparam logic [2:0] POP      = 3'd2;
    localparam logic [2:0] POP2PUSH = 3'd3;
    localparam logic [2:0] DUP      = 3'd4;
    localparam logic [2:0] SWAP     = 3'd5;
    localparam logic [2:0] ROT      = 3'd6;
    localparam logic [2:0] REPLACE  = 3'd7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [2:0]       op = NOP;
    logic [WIDTH-1:0] din = '0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] tos, nos, ros;
    logic [4:0]       depth;
    logic             empty, full, err;
    logic [1:0]       err_code;
    logic             err_clr = 1'b0;

    typedef struct {
        logic [15:0] t;
        logic [15:0] n;
        logic [15:0] r;
        logic [4:0]  d;
        logic        e;
        logic        f;
        logic        er;
        logic [1:0]  ec;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .din(din), .clr(clr), .tos(tos), .nos(nos), .ros(ros),
        .depth(depth), .empty(empty), .full(full), .err(err),
        .err_code(err_code), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] t, input logic [15:0] n, input logic [15:0] r,
                                input int d, input logic er, input logic [1:0] ec);
        exp_t x;
        x.t  = t;
        x.n  = n;
        x.r  = r;
        x.d  = 5'(d);
        x.e  = (d == 0);
        x.f  = (d == DEPTH);
        x.er = er;
        x.ec = ec;
        return x;
    endfunction

    task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s observed empty-scoreboard expected entry", tag);
        end else begin
            x = sb.pop_front();
            checkField({tag, "_tos"},   32'(tos),      32'(x.t));
            checkField({tag, "_nos"},   32'(nos),      32'(x.n));
            checkField({tag, "_ros"},   32'(ros),      32'(x.r));
            checkField({tag, "_depth"}, 32'(depth),    32'(x.d));
            checkField({tag, "_empty"}, 32'(empty),    32'(x.e));
            checkField({tag, "_full"},  32'(full),     32'(x.f));
            checkField({tag, "_err"},   32'(err),      32'(x.er));
            checkField({tag, "_code"},  32'(err_code), 32'(x.ec));
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] o, input logic v,
                                 input logic [15:0] d, input logic c, input logic ec, input exp_t x);
        op       = o;
        op_valid = v;
        din      = d;
        clr      = c;
        err_clr  = ec;
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        clr      = 1'b0;
        err_clr  = 1'b0;
        op       = NOP;
        checkOutput(tag);
    endtask

    task automatic waitReady(input string tag);
        int n;
        n = 0;
        while (!op_ready && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checkField({tag, "_clear_cycles"}, 32'(n), 32'd16);
    endtask

    task automatic fillStack(input string tag, input logic er, input logic [1:0] ec);
        logic [15:0] t;
        for (int i = 0; i < DEPTH; i++) begin
            t = 16'(16'h10 + i);
            applyStimulus(tag, PUSH, 1'b1, t, 1'b0, 1'b0,
                          mk(t, (i >= 1) ? t - 16'd1 : 16'd0, (i >= 2) ? t - 16'd2 : 16'd0, i + 1, er, ec));
        end
    endtask

    task automatic drainStack(input string tag, input logic er, input logic [1:0] ec);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            applyStimulus(tag, POP, 1'b1, 16'd0, 1'b0, 1'b0,
                          mk((i >= 1) ? 16'(16'h10 + i - 1) : 16'd0,
                             (i >= 2) ? 16'(16'h10 + i - 2) : 16'd0,
                             (i >= 3) ? 16'(16'h10 + i - 3) : 16'd0, i, er, ec));
        end
    endtask

    initial begin
        $display("[TB] reset and initial clear");
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkField("rst_ready", 32'(op_ready), 32'd0);
        sb.push_back(mk(16'd0, 16'd0, 16'd0, 0, 1'b0, 2'b00));
        checkOutput("rst");
        rst_n = 1'b1;
        waitReady("rst");
        sb.push_back(mk(16'd0, 16'd0, 16'd0, 0, 1'b0, 2'b00));
        checkOutput("post_clear");

        $display("[TB] push, rot, swap");
        applyStimulus("push1", PUSH, 1'b1, 16'h1, 1'b0, 1'b0, mk(16'h1, 16'h0, 16'h0, 1, 1'b0, 2'b00));
        applyStimulus("push2", PUSH, 1'b1, 16'h2, 1'b0, 1'b0, mk(16'h2, 16'h1, 16'h0, 2, 1'b0, 2'b00));
        applyStimulus("push3", PUSH, 1'b1, 16'h3, 1'b0, 1'b0, mk(16'h3, 16'h2, 16'h1, 3, 1'b0, 2'b00));
        applyStimulus("rot",   ROT,  1'b1, 16'h0, 1'b0, 1'b0, mk(16'h1, 16'h3, 16'h2, 3, 1'b0, 2'b00));
        applyStimulus("swap",  SWAP, 1'b1, 16'h0, 1'b0, 1'b0, mk(16'h3, 16'h1, 16'h2, 3, 1'b0, 2'b00));
        applyStimulus("idle",  PUSH, 1'b0, 16'h9, 1'b0, 1'b0, mk(16'h3, 16'h1, 16'h2, 3, 1'b0, 2'b00));

        $display("[TB] pop2push, dup, replace");
        applyStimulus("pop_a", POP, 1'b1, 16'h0, 1'b0, 1'b0, mk(16'h1, 16'h2, 16'h0, 2, 1'b0, 2'b00));
        applyStimulus("pop_b", POP, 1'b1, 16'h0, 1'b0, 1'b0, mk(16'h2, 16'h0, 16'h0, 1, 1'b0, 2'b00));
        applyStimulus("pop_c", POP, 1'b1, 16'h0, 1'b0, 1'b0, mk(16'h0, 16'h0, 16'h0, 0, 1'b0, 2'b00));
        applyStimulus("repush1", PUSH, 1'b1, 16'h1, 1'b0, 1'b0, mk(16'h1, 16'h0, 16'h0, 1, 1'b0, 2'b00));
        applyStimulus("repush2", PUSH, 1'b1, 16'h2, 1'b0, 1'b0, mk(16'h2, 16'h1, 16'h0, 2, 1'b0, 2'b00));
        applyStimulus("repush3", PUSH, 1'b1, 16'h3, 1'b0, 1'b0, mk(16'h3, 16'h2, 16'h1, 3, 1'b0, 2'b00));
        applyStimulus("pop2push", POP2PUSH, 1'b1, 16'h5, 1'b0, 1'b0, mk(16'h5, 16'h1, 16'h0, 2, 1'b0, 2'b00));
        applyStimulus("dup",     DUP,     1'b1, 16'h0, 1'b0, 1'b0, mk(16'h5, 16'h5, 16'h1, 3, 1'b0, 2'b00));
        applyStimulus("replace", REPLACE, 1'b1, 16'h7, 1'b0, 1'b0, mk(16'h7, 16'h5, 16'h1, 3, 1'b0, 2'b00));
        applyStimulus("nop",     NOP,     1'b1, 16'h0, 1'b0, 1'b0, mk(16'h7, 16'h5, 16'h1, 3, 1'b0, 2'b00));
        applyStimulus("pop_d", POP, 1'b1, 16'h0, 1'b0, 1'b0, mk(16'h5, 16'h1, 16'h0, 2, 1'b0, 2'b00));
        applyStimulus("pop_e", POP, 1'b1, 16'h0, 1'b0, 1'b0, mk(16'h1, 16'h0, 16'h0, 1, 1'b0, 2'b00));
        applyStimulus("pop_f", POP, 1'b1, 16'h0, 1'b0, 1'b0, mk(16'h0, 16'h0, 16'h0, 0, 1'b0, 2'b00));

`ifdef STACK_GUARD_EN
        $display("[TB] guarded overflow and underflow");
        fillStack("fill", 1'b0, 2'b00);
        applyStimulus("ovf",    PUSH, 1'b1, 16'hAAAA, 1'b0, 1'b0, mk(16'h1F, 16'h1E, 16'h1D, 16, 1'b1, 2'b10));
        applyStimulus("errclr", NOP,  1'b0, 16'h0,    1'b0, 1'b1, mk(16'h1F, 16'h1E, 16'h1D, 16, 1'b0, 2'b00));
        drainStack("drain", 1'b0, 2'b00);
        applyStimulus("unf",    POP,  1'b1, 16'h0,    1'b0, 1'b0, mk(16'h0, 16'h0, 16'h0, 0, 1'b1, 2'b01));
        fillStack("refill", 1'b1, 2'b01);
        applyStimulus("ovf_sticky", DUP,  1'b1, 16'h0,    1'b0, 1'b0, mk(16'h1F, 16'h1E, 16'h1D, 16, 1'b1, 2'b01));
        applyStimulus("ovf_clr",    PUSH, 1'b1, 16'hBBBB, 1'b0, 1'b1, mk(16'h1F, 16'h1E, 16'h1D, 16, 1'b1, 2'b10));
        applyStimulus("errclr2",    NOP,  1'b0, 16'h0,    1'b0, 1'b1, mk(16'h1F, 16'h1E, 16'h1D, 16, 1'b0, 2'b00));
        drainStack("drain2", 1'b0, 2'b00);
`else
        $display("[TB] unguarded wraparound");
        applyStimulus("pop_wrap",  POP,  1'b1, 16'h0,  1'b0, 1'b0, mk(16'h0, 16'h0, 16'h0, 15, 1'b0, 2'b00));
        applyStimulus("push_wrap", PUSH, 1'b1, 16'h55, 1'b0, 1'b0, mk(16'h0, 16'h0, 16'h0, 0, 1'b0, 2'b00));
        for (int i = 0; i < DEPTH; i++) begin
            logic [15:0] t;
            t = 16'(16'h20 + i);
            if (i == DEPTH - 1)
                applyStimulus("wrapfill", PUSH, 1'b1, t, 1'b0, 1'b0, mk(16'h0, 16'h0, 16'h0, 0, 1'b0, 2'b00));
            else
                applyStimulus("wrapfill", PUSH, 1'b1, t, 1'b0, 1'b0,
                              mk(t, (i >= 1) ? t - 16'd1 : 16'd0, (i >= 2) ? t - 16'd2 : 16'd0, i + 1, 1'b0, 2'b00));
        end
`endif

        $display("[TB] clear with op, reset during clear");
        for (int i = 0; i < 5; i++) begin
            logic [15:0] t;
            t = 16'(16'h30 + i);
            applyStimulus("pre_clr", PUSH, 1'b1, t, 1'b0, 1'b0,
                          mk(t, (i >= 1) ? t - 16'd1 : 16'd0, (i >= 2) ? t - 16'd2 : 16'd0, i + 1, 1'b0, 2'b00));
        end
        applyStimulus("clr_push", PUSH, 1'b1, 16'hBEEF, 1'b1, 1'b0, mk(16'h0, 16'h0, 16'h0, 0, 1'b0, 2'b00));
        checkField("clr_ready", 32'(op_ready), 32'd0);
        waitReady("clr");
        applyStimulus("push_after_clr", PUSH, 1'b1, 16'h77, 1'b0, 1'b0, mk(16'h77, 16'h0, 16'h0, 1, 1'b0, 2'b00));
        applyStimulus("clr_only", NOP, 1'b0, 16'h0, 1'b1, 1'b0, mk(16'h0, 16'h0, 16'h0, 0, 1'b0, 2'b00));
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checkField("midclr_rst_ready", 32'(op_ready), 32'd0);
        checkField("midclr_rst_depth", 32'(depth),    32'd0);
        #1;
        rst_n = 1'b1;
        waitReady("midclr_rst");
        sb.push_back(mk(16'd0, 16'd0, 16'd0, 0, 1'b0, 2'b00));
        checkOutput("after_midclr_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
